// File: rtl/game_collision_pkg.sv
// Shared types and helpers for the game collision detector.
//   coll_state_t      : IDLE (pixels ignored) / ACCUM (pixels counted)
//   N_TARGETS_DEFAULT : default number of target sprites
//   sat_inc           : saturating increment, clamps at max
package game_collision_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } coll_state_t;

    localparam int N_TARGETS_DEFAULT = 3;

    // Counters are at most 8 bits wide (MIN_OVERLAP <= 255), so the helper
    // works on 8 bits and callers cast to their own width.
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic [7:0] max);
        return (cnt >= max) ? max : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/game_overlap_counter.sv
// Saturating overlap-pixel counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one overlapping pixel this cycle
//   clr        : return to zero (takes priority over inc)
//   met        : count has reached MAX
module game_overlap_counter
    import game_collision_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic met
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = CW'(sat_inc(8'(cnt_q), 8'(MAX)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign met = (cnt_q == CW'(MAX));

endmodule

// File: rtl/game_collision_detector.sv
// Frame-based collision detector feeding the game master FSM.
// Counts spaceship/target and bullet/target overlap pixels over one video
// frame and, at the next frame edge (inactive->active vsync), emits 1-cycle
// registered pulses.
//   clk, rst_n        : pixel clock, asynchronous active-low reset
//   vsync, display_on : display timing
//   target_rgb_en     : per-target opaque flags
//   bullet_rgb_en     : bullet opaque flag
//   spaceship_rgb_en  : spaceship opaque flag
//   clear             : drop the current frame and return to IDLE
//   collision         : pulse, spaceship hit a target
//   collision_bullet  : pulse, bullet hit a target
//   hit_target        : targets hit by the bullet, valid with collision_bullet
// Optional macro GAME_COLLISION_FRAME_FILTER_EN: a hit must be seen in two
// consecutive evaluated frames before it pulses.
module game_collision_detector
    import game_collision_pkg::*;
#(
    parameter int N_TARGETS   = N_TARGETS_DEFAULT,
    parameter int MIN_OVERLAP = 4,
    parameter bit VSYNC_POL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 vsync,
    input  logic                 display_on,
    input  logic [N_TARGETS-1:0] target_rgb_en,
    input  logic                 bullet_rgb_en,
    input  logic                 spaceship_rgb_en,
    input  logic                 clear,
    output logic                 collision,
    output logic                 collision_bullet,
    output logic [N_TARGETS-1:0] hit_target
);

    coll_state_t          state_q, state_d;
    logic                 vsync_act_q, vsync_act_d;
    logic                 collision_q, collision_d;
    logic                 collision_bullet_q, collision_bullet_d;
    logic [N_TARGETS-1:0] hit_target_q, hit_target_d;

    logic                 vsync_act;
    logic                 frame_edge;
    logic                 eval;
    logic                 counting;
    logic                 cnt_clr;
    logic                 ship_inc;
    logic                 ship_met;
    logic [N_TARGETS-1:0] bul_inc;
    logic [N_TARGETS-1:0] bul_met;

    // Normalise vsync polarity; the edge register resets to "inactive" so a
    // vsync already active out of reset still produces one edge.
    assign vsync_act   = (vsync == VSYNC_POL);
    assign vsync_act_d = vsync_act;
    assign frame_edge  = vsync_act & ~vsync_act_q;

    // A frame is evaluated only from ACCUM; clear in the same cycle cancels it.
    assign eval     = (state_q == ACCUM) & frame_edge & ~clear;
    assign counting = (state_q == ACCUM) & display_on;
    // Counters are held at zero in IDLE so a partial frame never leaks in.
    assign cnt_clr  = (state_q != ACCUM) | clear | frame_edge;

    assign ship_inc = counting & spaceship_rgb_en & (|target_rgb_en);
    assign bul_inc  = {N_TARGETS{counting & bullet_rgb_en}} & target_rgb_en;

    game_overlap_counter #(.MAX(MIN_OVERLAP)) u_ship_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ship_inc),
        .clr   (cnt_clr),
        .met   (ship_met)
    );

    for (genvar gi = 0; gi < N_TARGETS; gi++) begin : g_bul_cnt
        game_overlap_counter #(.MAX(MIN_OVERLAP)) u_bul_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (bul_inc[gi]),
            .clr   (cnt_clr),
            .met   (bul_met[gi])
        );
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_edge && !clear) state_d = ACCUM;
            ACCUM:   if (clear)                state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef GAME_COLLISION_FRAME_FILTER_EN
    // Sticky bits hold "threshold met last evaluated frame". A bit that fires
    // is cleared so a third consecutive hit frame needs a fresh pair.
    logic                 ship_sticky_q, ship_sticky_d;
    logic [N_TARGETS-1:0] bul_sticky_q, bul_sticky_d;

    // FSM: outputs
    always_comb begin
        collision_d   = 1'b0;
        hit_target_d  = '0;
        ship_sticky_d = ship_sticky_q;
        bul_sticky_d  = bul_sticky_q;
        if (clear) begin
            ship_sticky_d = 1'b0;
            bul_sticky_d  = '0;
        end else if (eval) begin
            collision_d   = ship_met & ship_sticky_q;
            ship_sticky_d = ship_met & ~ship_sticky_q;
            hit_target_d  = bul_met & bul_sticky_q;
            bul_sticky_d  = bul_met & ~bul_sticky_q;
        end
        collision_bullet_d = |hit_target_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ship_sticky_q <= 1'b0;
            bul_sticky_q  <= '0;
        end else begin
            ship_sticky_q <= ship_sticky_d;
            bul_sticky_q  <= bul_sticky_d;
        end
    end
`else
    // FSM: outputs
    always_comb begin
        collision_d  = 1'b0;
        hit_target_d = '0;
        if (eval) begin
            collision_d  = ship_met;
            hit_target_d = bul_met;
        end
        collision_bullet_d = |hit_target_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_act_q        <= 1'b0;
            collision_q        <= 1'b0;
            collision_bullet_q <= 1'b0;
            hit_target_q       <= '0;
        end else begin
            vsync_act_q        <= vsync_act_d;
            collision_q        <= collision_d;
            collision_bullet_q <= collision_bullet_d;
            hit_target_q       <= hit_target_d;
        end
    end

    assign collision        = collision_q;
    assign collision_bullet = collision_bullet_q;
    assign hit_target       = hit_target_q;

endmodule

// File: tb/tb_game_collision_detector.sv
// Bench for game_collision_detector (default parameters: 3 targets,
// threshold 4, active-low vsync). A frame-level reference model counts raw
// overlaps per frame and pushes the expected pulse (with its cycle stamp)
// into exp_q; a monitor pops and compares whenever the DUT pulses.
// Honours GAME_COLLISION_FRAME_FILTER_EN in the model as well.
module tb_game_collision_detector;

  localparam int NT  = 3;
  localparam int MIN = 4;
  localparam int W   = 16 + 1 + 1 + NT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vsync = 1'b1;
  logic          display_on = 1'b0;
  logic [NT-1:0] target_rgb_en = '0;
  logic          bullet_rgb_en = 1'b0;
  logic          spaceship_rgb_en = 1'b0;
  logic          clear = 1'b0;
  logic          collision;
  logic          collision_bullet;
  logic [NT-1:0] hit_target;

  game_collision_detector #(
    .N_TARGETS   (NT),
    .MIN_OVERLAP (MIN),
    .VSYNC_POL   (1'b0)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .vsync            (vsync),
    .display_on       (display_on),
    .target_rgb_en    (target_rgb_en),
    .bullet_rgb_en    (bullet_rgb_en),
    .spaceship_rgb_en (spaceship_rgb_en),
    .clear            (clear),
    .collision        (collision),
    .collision_bullet (collision_bullet),
    .hit_target       (hit_target)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model ----------------
  bit      armed;
  int      ship_cnt;
  int      bul_cnt[NT];
  bit      ship_prev;
  bit [NT-1:0] bul_prev;

  function automatic void model_reset_frame();
    ship_cnt = 0;
    for (int i = 0; i < NT; i++) bul_cnt[i] = 0;
  endfunction

  function automatic void model_drop_all();
    armed = 1'b0;
    ship_prev = 1'b0;
    bul_prev = '0;
    model_reset_frame();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic pixel(input logic d, input logic [NT-1:0] t, input logic b, input logic s);
    @(negedge clk);
    display_on = d; target_rgb_en = t; bullet_rgb_en = b; spaceship_rgb_en = s;
    if (armed && d) begin
      if (s && (t != 0)) ship_cnt++;
      for (int i = 0; i < NT; i++) if (b && t[i]) bul_cnt[i]++;
    end
  endtask

  task automatic idle_px(input int n);
    repeat (n) pixel(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Vsync goes active at this negedge, so the DUT sees the edge in the
  // cycle ending at posedge cyc+1 and the pulse is registered there.
  task automatic frame_edge(input bit with_clear);
    bit          f_ship;
    bit [NT-1:0] f_bul;
    bit          m_ship;
    bit [NT-1:0] m_bul;
    @(negedge clk);
    display_on = 1'b0; target_rgb_en = '0; bullet_rgb_en = 1'b0; spaceship_rgb_en = 1'b0;
    vsync = 1'b0;
    clear = with_clear;
    if (with_clear) begin
      model_drop_all();
    end else if (!armed) begin
      armed = 1'b1;
      model_reset_frame();
    end else begin
      m_ship = (ship_cnt >= MIN);
      for (int i = 0; i < NT; i++) m_bul[i] = (bul_cnt[i] >= MIN);
`ifdef GAME_COLLISION_FRAME_FILTER_EN
      f_ship = m_ship && ship_prev;
      f_bul  = m_bul & bul_prev;
      ship_prev = m_ship && !f_ship;
      bul_prev  = m_bul & ~f_bul;
`else
      f_ship = m_ship;
      f_bul  = m_bul;
`endif
      if (f_ship || (f_bul != 0))
        exp_q.push_back({16'(cyc + 1), f_ship, (f_bul != 0), f_bul});
      model_reset_frame();
    end
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_collision"}, 32'(collision), 32'd0);
    chk({tag, "_collision_bullet"}, 32'(collision_bullet), 32'd0);
    chk({tag, "_hit_target"}, 32'(hit_target), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && (collision || collision_bullet || hit_target != 0)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got col=%0b colb=%0b hit=%b expected no pulse (cycle %0d)",
                 collision, collision_bullet, hit_target, cyc);
      end else begin
        chk("pulse", 32'({16'(cyc), collision, collision_bullet, hit_target}), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_drop_all();
    repeat (3) @(negedge clk);
    check_quiet("reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_quiet("reset_release");

    // First edge only arms the detector.
    frame_edge(1'b0);

    // Ship/target[1], exactly at threshold.
    repeat (4) pixel(1'b1, 3'b010, 1'b0, 1'b1);
    idle_px(3);
    frame_edge(1'b0);

    // Bullet/target[2]: below threshold, then above.
    repeat (3) pixel(1'b1, 3'b100, 1'b1, 1'b0);
    idle_px(2);
    frame_edge(1'b0);
    repeat (5) pixel(1'b1, 3'b100, 1'b1, 1'b0);
    frame_edge(1'b0);

    // Multi-hit: bullet on targets 0 and 2 plus ship, same cycles.
    repeat (4) pixel(1'b1, 3'b101, 1'b1, 1'b1);
    frame_edge(1'b0);

    // Same again: under the frame filter this is the confirming frame.
    repeat (4) pixel(1'b1, 3'b101, 1'b1, 1'b1);
    frame_edge(1'b0);

    // Clear at the edge, then an arming edge, then a normal frame.
    repeat (4) pixel(1'b1, 3'b001, 1'b0, 1'b1);
    frame_edge(1'b1);
    repeat (4) pixel(1'b1, 3'b001, 1'b0, 1'b1);
    frame_edge(1'b0);
    repeat (4) pixel(1'b1, 3'b001, 1'b0, 1'b1);
    frame_edge(1'b0);
    repeat (4) pixel(1'b1, 3'b001, 1'b0, 1'b1);
    frame_edge(1'b0);

    // Display gating.
    repeat (10) pixel(1'b0, 3'b111, 1'b1, 1'b1);
    frame_edge(1'b0);

    // Reset mid-frame discards the frame.
    repeat (6) pixel(1'b1, 3'b010, 1'b1, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    model_drop_all();
    @(negedge clk);
    check_quiet("mid_reset");
    rst_n = 1'b1;
    frame_edge(1'b0);
    idle_px(2);
    check_quiet("after_reset_arm");

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      for (int p = 0; p < 40; p++) begin
        pixel(($urandom_range(0, 4) != 0), NT'($urandom), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0));
      end
      if ($urandom_range(0, 12) == 0) begin
        @(negedge clk);
        display_on = 1'b0;
        clear = 1'b1;
        model_drop_all();
        @(negedge clk);
        clear = 1'b0;
      end
      frame_edge($urandom_range(0, 9) == 0);
    end

    idle_px(5);
    chk("pending_expected", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
